// File: rtl/nn_config_loader.sv
// Streams one layer of weights and biases from a 32-bit word source
// onto the neuron configuration bus, one word per cycle.
module nn_config_loader #(
  parameter int cntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         cfg_layer,
  input  logic [cntWidth-1:0] cfg_num_neurons,
  input  logic [cntWidth-1:0] cfg_num_weights,
  input  logic [31:0]         s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                weightValid,
  output logic [31:0]         weightValue,
  output logic                biasValid,
  output logic [31:0]         biasValue,
  output logic [31:0]         configLayerNum,
  output logic [31:0]         configNeuronNum,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    WEIGHT,
    BIAS,
    DONE
  } state_t;

  localparam logic [cntWidth-1:0] ONE = cntWidth'(1);

  state_t              state_q, state_d;
  logic [cntWidth-1:0] neuron_cnt_q, neuron_cnt_d;
  logic [cntWidth-1:0] weight_cnt_q, weight_cnt_d;
  logic [cntWidth-1:0] num_neurons_q, num_neurons_d;
  logic [cntWidth-1:0] num_weights_q, num_weights_d;
  logic [31:0]         layer_q, layer_d;
  logic [31:0]         neuron_num_q, neuron_num_d;
  logic [31:0]         wvalue_q, wvalue_d;
  logic [31:0]         bvalue_q, bvalue_d;
  logic                wvalid_q, wvalid_d;
  logic                bvalid_q, bvalid_d;
  logic                done_q, done_d;
  logic                accept;

  assign s_ready = (state_q == WEIGHT) || (state_q == BIAS);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d       = state_q;
    neuron_cnt_d  = neuron_cnt_q;
    weight_cnt_d  = weight_cnt_q;
    num_neurons_d = num_neurons_q;
    num_weights_d = num_weights_q;
    layer_d       = layer_q;
    neuron_num_d  = neuron_num_q;
    wvalue_d      = wvalue_q;
    bvalue_d      = bvalue_q;
    wvalid_d      = 1'b0;
    bvalid_d      = 1'b0;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          layer_d       = cfg_layer;
          num_neurons_d = cfg_num_neurons;
          num_weights_d = cfg_num_weights;
          neuron_cnt_d  = '0;
          weight_cnt_d  = '0;
          if (cfg_num_neurons == '0)
            state_d = DONE;
          else if (cfg_num_weights == '0)
            state_d = BIAS;
          else
            state_d = WEIGHT;
        end
      end
      WEIGHT: begin
        if (accept) begin
          wvalid_d     = 1'b1;
          wvalue_d     = s_data;
          neuron_num_d = 32'(neuron_cnt_q);
          if (weight_cnt_q == num_weights_q - ONE) begin
            weight_cnt_d = '0;
            state_d      = BIAS;
          end else begin
            weight_cnt_d = weight_cnt_q + ONE;
          end
        end
      end
      BIAS: begin
        if (accept) begin
          bvalid_d     = 1'b1;
          bvalue_d     = s_data;
          neuron_num_d = 32'(neuron_cnt_q);
          if (neuron_cnt_q == num_neurons_q - ONE) begin
            state_d = DONE;
          end else begin
            neuron_cnt_d = neuron_cnt_q + ONE;
            // weightless layers run bias after bias
            state_d = (num_weights_q == '0) ? BIAS : WEIGHT;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      neuron_cnt_q  <= '0;
      weight_cnt_q  <= '0;
      num_neurons_q <= '0;
      num_weights_q <= '0;
      layer_q       <= '0;
      neuron_num_q  <= '0;
      wvalue_q      <= '0;
      bvalue_q      <= '0;
      wvalid_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      neuron_cnt_q  <= neuron_cnt_d;
      weight_cnt_q  <= weight_cnt_d;
      num_neurons_q <= num_neurons_d;
      num_weights_q <= num_weights_d;
      layer_q       <= layer_d;
      neuron_num_q  <= neuron_num_d;
      wvalue_q      <= wvalue_d;
      bvalue_q      <= bvalue_d;
      wvalid_q      <= wvalid_d;
      bvalid_q      <= bvalid_d;
      done_q        <= done_d;
    end
  end

  assign weightValid     = wvalid_q;
  assign weightValue     = wvalue_q;
  assign biasValid       = bvalid_q;
  assign biasValue       = bvalue_q;
  assign configLayerNum  = layer_q;
  assign configNeuronNum = neuron_num_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

endmodule

// File: doc/nn_config_loader.md
# nn_config_loader

Streams trained weights and biases from a 32-bit word source onto the neuron configuration bus (`weightValid`, `biasValid`, `weightValue`, `biasValue`, `configLayerNum`, `configNeuronNum`). The neurons are the receivers on that bus; this block is the transmitter. It sits between the host/DMA word stream and every neuron of the network. One `start` command loads one layer: for each neuron in order, it sends `num_weights` weights followed by one bias.

## Interface
Parameters:
- `cntWidth`, 16: width of the neuron-count and weight-count command fields and of the internal counters.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  command strobe; sampled only in IDLE
- `cfg_layer`  in  32  layer number for this load; latched on an accepted `start`
- `cfg_num_neurons`  in  cntWidth  neurons in the layer; latched on an accepted `start`
- `cfg_num_weights`  in  cntWidth  weights per neuron; latched on an accepted `start`
- `s_data`  in  32  input word stream
- `s_valid`  in  1  `s_data` is valid
- `s_ready`  out  1  loader accepts a word this cycle
- `weightValid`  out  1  one-cycle pulse per weight
- `weightValue`  out  32  weight word, passed through unmodified
- `biasValid`  out  1  one-cycle pulse per bias
- `biasValue`  out  32  bias word, passed through unmodified
- `configLayerNum`  out  32  target layer
- `configNeuronNum`  out  32  target neuron index, zero-extended
- `busy`  out  1  a load is in progress
- `done`  out  1  one-cycle pulse when a load completes

## Operation
- FSM states: IDLE, WEIGHT, BIAS, DONE.
- IDLE:
  - `start`=1 latches `cfg_*` and clears `neuron_cnt` and `weight_cnt`.
  - Next state: DONE if `cfg_num_neurons`==0; otherwise BIAS if `cfg_num_weights`==0; otherwise WEIGHT.
- Word acceptance: `s_ready` = (state==WEIGHT or state==BIAS), combinational from state only. A word is accepted when `s_valid & s_ready`.
- WEIGHT: each accepted word produces a weight transfer.
  - `weight_cnt` increments on each accepted word.
  - On the word where `weight_cnt`==num_weights-1, clear `weight_cnt` and go to BIAS.
- BIAS: an accepted word produces a bias transfer.
  - If `neuron_cnt`==num_neurons-1, go to DONE.
  - Otherwise increment `neuron_cnt` and go to WEIGHT, or stay in BIAS when num_weights==0.
- DONE: lasts exactly one cycle, then IDLE.
- `start` outside IDLE is ignored and has no effect on the latched `cfg_*` values.
- No back-pressure from neurons: every transfer is a single-cycle pulse.
- `weightValue`/`biasValue` hold their last value between pulses. `configLayerNum` holds the latched layer until the next accepted `start`.
- Counters are unsigned, `cntWidth` bits. No wrap: the comparisons above terminate each loop before any overflow.

## Timing
- Reset: outputs and internal state are cleared.
  - `s_ready`, `weightValid`, `biasValid`, `busy`, `done` = 0.
  - `weightValue`, `biasValue`, `configLayerNum`, `configNeuronNum` = 0.
  - State = IDLE; counters = 0.
- Reset mid-load: the partial load is discarded and no further pulses are issued. Neurons keep whatever they already received.
- All bus outputs are registered. A word accepted in cycle N appears in cycle N+1 as:
  - `weightValid` or `biasValid` = 1;
  - the value on `weightValue`/`biasValue`;
  - `configNeuronNum` = neuron index of that word.
  - `configLayerNum` is stable in the same cycle.
- This alignment is mandatory: neurons qualify `weightValid`/`biasValid` with `configLayerNum`/`configNeuronNum` in the same cycle.
- Throughput: one word per cycle while `s_valid` stays high. Zero-bubble across the WEIGHT→BIAS and BIAS→WEIGHT transitions.
- `start` accepted in cycle S: state leaves IDLE in S+1, and `s_ready` can first be 1 in S+1.
- `busy` = 1 from S+1 through the DONE cycle.
- Final bias accepted in cycle N:
  - `biasValid` pulses in N+1, which is also the DONE cycle;
  - `done` pulses in N+2;
  - `busy` is 0 from N+2;
  - a new `start` is accepted from N+2.
- Zero neurons: `start` in S gives DONE in S+1 and `done` in S+2, with no transfers.
- Simultaneous `start` and the DONE→IDLE transition: `start` is ignored because the state is not yet IDLE.

## Test plan
- layer=1, neurons=2, weights=3, words 0xA0..0xA7 with `s_valid` held high:
  - weight pulses A0,A1,A2 (neuron 0), bias A3 (neuron 0), weights A4..A6 (neuron 1), bias A7 (neuron 1);
  - pulses on 8 consecutive cycles;
  - `configLayerNum`=1 throughout;
  - `done` one cycle after the last `biasValid`.
- Same load with `s_valid` toggled 1,0,1,0: pulses appear only the cycle after an accepted word; the order and neuron indices are unchanged.
- neurons=3, weights=0: exactly 3 `biasValid` pulses with neuron numbers 0,1,2, no `weightValid`, then `done`.
- neurons=0: `done` two cycles after `start`; `s_ready` never asserts.
- `start` with layer=5 asserted mid-load: ignored; `configLayerNum` stays at the original layer and the load completes normally.
- `rst` asserted after the 2nd weight: all outputs return to 0 the next cycle and no further pulses occur. A new `start` afterwards loads from neuron 0, weight 0.
